// File: rtl/tdm_pkg.sv
// Shared TDM datapath definitions: default widths and lane/word types used by the
// round-robin mux, the multiplier and the lane deinterleaver.
package tdm_pkg;

   localparam int TDM_DATA_WIDTH = 16;
   localparam int TDM_NUM_LANES  = 2;

   typedef logic [$clog2(TDM_NUM_LANES)-1:0] lane_idx_t;
   typedef logic [TDM_DATA_WIDTH-1:0]        word_t;

endpackage

// File: rtl/tdm_lane_deinterleaver_lane_fifo.sv
// Single-clock show-ahead FIFO for one lane. The head word lives in a register so it is
// presented one cycle after its write and holds its last value while the FIFO is empty.
module lane_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic [DATA_WIDTH-1:0]                push_data,
   input  logic                                 pop,
   output logic [DATA_WIDTH-1:0]                head,
   output logic                                 full,
   output logic                                 empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         rd_next;
   logic [CW-1:0]         count_next;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // The head reloads only when it is consumed or the FIFO was empty; a word written this
   // cycle into the slot about to become the head bypasses the memory.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_next;
         count  <= count_next;
         if ((count_next != '0) && (do_pop || empty)) begin
            head <= (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/tdm_lane_deinterleaver.sv
// Splits the interleaved TDM product stream back into per-lane show-ahead FIFOs, tracking
// the slot position and flagging frame misalignment and dropped words.
module tdm_lane_deinterleaver
   import tdm_pkg::*;
#(
   parameter int DATA_WIDTH = TDM_DATA_WIDTH,
   parameter int NUM_LANES  = TDM_NUM_LANES,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [DATA_WIDTH-1:0]                         din,
   input  logic                                          din_valid,
   input  logic                                          din_sof,
   output logic [NUM_LANES*DATA_WIDTH-1:0]               dout,
   output logic [NUM_LANES-1:0]                          dout_valid,
   input  logic [NUM_LANES-1:0]                          dout_ready,
   output logic [NUM_LANES-1:0]                          overflow,
   output logic                                          sync_err,
   output logic [NUM_LANES*$clog2(FIFO_DEPTH+1)-1:0]     fill_level
);

   localparam int LW = $clog2(NUM_LANES);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [LW-1:0]        slot;
   logic [LW-1:0]        lane_sel;
   logic [NUM_LANES-1:0] lane_hit;
   logic [NUM_LANES-1:0] lane_full;
   logic [NUM_LANES-1:0] lane_empty;
   logic [NUM_LANES-1:0] lane_pop;
   logic [NUM_LANES-1:0] lane_push;
   logic [NUM_LANES-1:0] lane_drop;

   // A frame start forces lane 0, realigning the stream on the very word that carries it.
   assign lane_sel = din_sof ? '0 : slot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
      end else if (din_valid) begin
         slot <= (lane_sel == LW'(NUM_LANES - 1)) ? '0 : lane_sel + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_err <= 1'b0;
         overflow <= '0;
      end else begin
         if (din_valid && din_sof && (slot != '0)) begin
            sync_err <= 1'b1;
         end
         overflow <= overflow | lane_drop;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_hit[i]   = din_valid && (lane_sel == LW'(i));
      assign lane_pop[i]   = dout_valid[i] & dout_ready[i];
      assign lane_push[i]  = lane_hit[i] & (~lane_full[i] | lane_pop[i]);
      assign lane_drop[i]  = lane_hit[i] & lane_full[i] & ~lane_pop[i];
      assign dout_valid[i] = ~lane_empty[i];

      lane_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (lane_push[i]),
         .push_data (din),
         .pop       (lane_pop[i]),
         .head      (dout[i*DATA_WIDTH +: DATA_WIDTH]),
         .full      (lane_full[i]),
         .empty     (lane_empty[i]),
         .count     (fill_level[i*CW +: CW])
      );
   end

endmodule

// File: tb/tb_tdm_lane_deinterleaver.sv
// Self-checking bench for tdm_lane_deinterleaver: a per-lane scoreboard queue is filled as
// words are driven and drained as the DUT presents and pops lane heads.
module tb_tdm_lane_deinterleaver;

   localparam int DW = 16;
   localparam int NL = 2;
   localparam int FD = 8;
   localparam int CW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    din;
   logic             din_valid;
   logic             din_sof;
   logic [NL*DW-1:0] dout;
   logic [NL-1:0]    dout_valid;
   logic [NL-1:0]    dout_ready;
   logic [NL-1:0]    overflow;
   logic             sync_err;
   logic [NL*CW-1:0] fill_level;

   int            errorCount = 0;
   int            checkCount = 0;
   logic [DW-1:0] expQ [NL][$];
   logic [DW-1:0] lastHead [NL];
   logic [NL-1:0] expOvf;
   logic          expSync;
   int            expSlot;

   tdm_lane_deinterleaver #(
      .DATA_WIDTH (DW),
      .NUM_LANES  (NL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overflow   (overflow),
      .sync_err   (sync_err),
      .fill_level (fill_level)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare every lane against the scoreboard; empty lanes must hold their previous head.
   task automatic checkAll();
      for (int i = 0; i < NL; i++) begin
         checkOutput($sformatf("lane%0d_valid", i), 32'(dout_valid[i]), (expQ[i].size() > 0) ? 32'd1 : 32'd0);
         if (expQ[i].size() > 0) begin
            checkOutput($sformatf("lane%0d_dout", i), 32'(dout[i*DW +: DW]), 32'(expQ[i][0]));
            lastHead[i] = expQ[i][0];
         end else begin
            checkOutput($sformatf("lane%0d_dout_hold", i), 32'(dout[i*DW +: DW]), 32'(lastHead[i]));
         end
         checkOutput($sformatf("lane%0d_fill", i), 32'(fill_level[i*CW +: CW]), 32'(expQ[i].size()));
         checkOutput($sformatf("lane%0d_overflow", i), 32'(overflow[i]), 32'(expOvf[i]));
      end
      checkOutput("sync_err", 32'(sync_err), 32'(expSync));
   endtask

   // Reference behaviour at a clock edge, evaluated from the pre-edge model state.
   task automatic modelEdge();
      logic [NL-1:0] popNow;
      logic          fullNow;
      int            lane;
      lane = 0;
      fullNow = 1'b0;
      for (int i = 0; i < NL; i++) begin
         popNow[i] = (expQ[i].size() > 0) && dout_ready[i];
      end
      if (din_valid) begin
         lane = din_sof ? 0 : expSlot;
         if (din_sof && expSlot != 0) expSync = 1'b1;
         expSlot = (lane + 1) % NL;
         fullNow = (expQ[lane].size() == FD);
      end
      for (int i = 0; i < NL; i++) begin
         if (popNow[i]) void'(expQ[i].pop_front());
      end
      if (din_valid) begin
         if (!fullNow || popNow[lane]) expQ[lane].push_back(din);
         else expOvf[lane] = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d, input logic [NL-1:0] rdy);
      din_valid  = v;
      din_sof    = s;
      din        = d;
      dout_ready = rdy;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
   endtask

   task automatic idle(input int n, input logic [NL-1:0] rdy);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, rdy);
   endtask

   task automatic clearModel();
      for (int i = 0; i < NL; i++) begin
         expQ[i].delete();
         lastHead[i] = '0;
      end
      expOvf  = '0;
      expSync = 1'b0;
      expSlot = 0;
   endtask

   // Reset is asserted mid-cycle so its effect is observed before the next rising edge.
   task automatic doAsyncReset();
      #2;
      din_valid = 1'b0;
      din_sof   = 1'b0;
      rst       = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(dout_valid), 32'd0);
      checkOutput("async_rst_fill", 32'(fill_level), 32'd0);
      checkOutput("async_rst_overflow", 32'(overflow), 32'd0);
      checkOutput("async_rst_sync", 32'(sync_err), 32'd0);
      clearModel();
      @(negedge clk);
      rst = 1'b0;
      checkAll();
   endtask

   initial begin
      rst        = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      din_sof    = 1'b0;
      dout_ready = '0;
      clearModel();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkAll();

      $display("[TB] basic interleave");
      for (int k = 1; k <= 8; k++) applyStimulus(1'b1, k == 1, 16'(16'h0100 + k), 2'b11);
      idle(2, 2'b11);

      $display("[TB] full lane with simultaneous push and pop");
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, k == 0, 16'(16'h0300 + k), 2'b10);
      applyStimulus(1'b1, 1'b0, 16'h0399, 2'b01);
      idle(9, 2'b11);

      $display("[TB] overflow with stalled consumers");
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, k == 0, 16'(16'h0200 + k), 2'b00);
      idle(10, 2'b11);
      doAsyncReset();

      $display("[TB] misaligned frame start");
      applyStimulus(1'b1, 1'b0, 16'h0401, 2'b11);
      applyStimulus(1'b1, 1'b1, 16'h0402, 2'b11);
      applyStimulus(1'b1, 1'b0, 16'h0403, 2'b11);
      applyStimulus(1'b1, 1'b0, 16'h0404, 2'b11);
      idle(2, 2'b11);

      $display("[TB] valid gaps");
      for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b0, 16'(16'h0500 + k), 2'b11);
      idle(3, 2'b11);
      for (int k = 4; k <= 6; k++) applyStimulus(1'b1, 1'b0, 16'(16'h0500 + k), 2'b11);
      idle(2, 2'b11);

      $display("[TB] async reset with buffered data");
      for (int k = 1; k <= 10; k++) applyStimulus(1'b1, 1'b0, 16'(16'h0600 + k), 2'b00);
      doAsyncReset();
      applyStimulus(1'b1, 1'b0, 16'h0701, 2'b11);
      applyStimulus(1'b1, 1'b0, 16'h0702, 2'b11);
      idle(2, 2'b11);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
